// File: rtl/gtech_link_deser.sv
// Receive end of the one-bit framed serial link: LSB-first WIDTH-bit frames plus an
// even-parity bit, delivered through a one-word valid/ready buffer with sticky error flags.
module gtech_link_deser #(
   parameter int WIDTH = 8
) (
   input  logic             CP,
   input  logic             CD,
   input  logic             S_DIN,
   input  logic             S_VLD,
   input  logic             S_SOF,
   output logic [WIDTH-1:0] DOUT,
   output logic             D_PERR,
   output logic             D_VLD,
   input  logic             D_RDY,
   input  logic             CLR_ERR,
   output logic             OVF,
   output logic             FERR,
   output logic             BUSY,
   output logic [1:0]       dbg_state_o
);

   localparam int CW = $clog2(WIDTH + 1);

   // Output handshake: a word transfers on every CP edge where D_VLD & D_RDY; DOUT and
   // D_PERR hold while D_VLD & !D_RDY, and D_RDY has no effect while D_VLD is low.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             perr_q, perr_d;
   logic             vld_q, vld_d;
   logic             ovf_q, ovf_d;
   logic             ferr_q, ferr_d;
   logic             frame_done, ferr_set, ovf_set, load;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      frame_done = 1'b0;
      ferr_set   = 1'b0;
      if (S_VLD) begin
         if (S_SOF) begin
            // SOF always restarts; it is only an error when a frame was already open.
            ferr_set = (state_q != IDLE);
            sh_d     = WIDTH'(S_DIN);
            cnt_d    = CW'(1);
            state_d  = DATA;
         end else begin
            case (state_q)
               IDLE: ferr_set = 1'b1;
               DATA: begin
                  sh_d  = sh_q | (WIDTH'(S_DIN) << cnt_q);
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_d == CW'(WIDTH)) state_d = PAR;
               end
               PAR: begin
                  frame_done = 1'b1;
                  cnt_d      = '0;
                  state_d    = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_comb begin
      load    = frame_done & (~vld_q | D_RDY);
      ovf_set = frame_done & ~load;
      dout_d  = dout_q;
      perr_d  = perr_q;
      vld_d   = vld_q;
      if (vld_q & D_RDY) vld_d = 1'b0;
      if (load) begin
         dout_d = sh_q;
         perr_d = ^{sh_q, S_DIN};
         vld_d  = 1'b1;
      end
      // A fresh error in the clearing cycle keeps the flag set.
      ovf_d  = (ovf_q & ~CLR_ERR) | ovf_set;
      ferr_d = (ferr_q & ~CLR_ERR) | ferr_set;
   end

   always_ff @(posedge CP or negedge CD) begin
      if (!CD) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         dout_q  <= '0;
         perr_q  <= 1'b0;
         vld_q   <= 1'b0;
         ovf_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         dout_q  <= dout_d;
         perr_q  <= perr_d;
         vld_q   <= vld_d;
         ovf_q   <= ovf_d;
         ferr_q  <= ferr_d;
      end
   end

   assign DOUT        = dout_q;
   assign D_PERR      = perr_q;
   assign D_VLD       = vld_q;
   assign OVF         = ovf_q;
   assign FERR        = ferr_q;
   assign BUSY        = (state_q != IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gtech_link_deser.sv
// Directed bench for gtech_link_deser: a frame table plus hand-written sequences for
// back-to-back, overflow, framing, sticky-clear and asynchronous reset cases.
module tb_gtech_link_deser;

   logic       CP, CD, S_DIN, S_VLD, S_SOF, D_RDY, CLR_ERR;
   logic [7:0] DOUT;
   logic       D_PERR, D_VLD, OVF, FERR, BUSY;
   logic [1:0] dbg_state;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic       par;
      int         gap_pos;
      int         gap_len;
      logic [7:0] exp_dout;
      logic       exp_perr;
   } vec_t;
   vec_t vecs[7];

   gtech_link_deser #(.WIDTH(8)) dut (
      .CP(CP), .CD(CD), .S_DIN(S_DIN), .S_VLD(S_VLD), .S_SOF(S_SOF),
      .DOUT(DOUT), .D_PERR(D_PERR), .D_VLD(D_VLD), .D_RDY(D_RDY),
      .CLR_ERR(CLR_ERR), .OVF(OVF), .FERR(FERR), .BUSY(BUSY),
      .dbg_state_o(dbg_state)
   );

   // clock / reset
   initial begin
      CP = 1'b0;
      forever #5 CP = ~CP;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // scoreboard: every accepted word must match the head of exp_q
   always @(posedge CP) begin
      if (CD && D_VLD && D_RDY) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected: got %0h expected no word", DOUT);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (DOUT !== e) begin
               bad++;
               $display("FAIL pop_data: got %0h expected %0h", DOUT, e);
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   task automatic send_bit(input logic din, input logic sof);
      S_VLD = 1'b1;
      S_SOF = sof;
      S_DIN = din;
      tick();
      S_VLD = 1'b0;
      S_SOF = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input int gap_pos, input int gap_len);
      for (int i = 0; i <= 8; i++) begin
         if (i == gap_pos) begin
            for (int g = 0; g < gap_len; g++) begin
               S_VLD = 1'b0;
               S_DIN = 1'($urandom_range(0, 1));
               S_SOF = 1'($urandom_range(0, 1));
               tick();
            end
            S_SOF = 1'b0;
         end
         send_bit((i < 8) ? d[i] : p, i == 0);
      end
   endtask

   task automatic pop_word();
      D_RDY = 1'b1;
      tick();
      D_RDY = 1'b0;
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b0, -1, 0, 8'hA5, 1'b0};
      vecs[1] = '{8'h01, 1'b0, -1, 0, 8'h01, 1'b1};
      vecs[2] = '{8'h3C, 1'b0,  4, 3, 8'h3C, 1'b0};
      vecs[3] = '{8'h80, 1'b1,  8, 2, 8'h80, 1'b0};
      vecs[4] = '{8'h80, 1'b0, -1, 0, 8'h80, 1'b1};
      vecs[5] = '{8'hFE, 1'b1,  0, 1, 8'hFE, 1'b0};
      vecs[6] = '{8'h00, 1'b1, -1, 0, 8'h00, 1'b1};

      CD = 1'b0; S_DIN = 1'b0; S_VLD = 1'b0; S_SOF = 1'b0; D_RDY = 1'b0; CLR_ERR = 1'b0;
      repeat (3) tick();
      check("rst_dout", DOUT, 0);
      check("rst_vld", D_VLD, 0);
      check("rst_busy", BUSY, 0);
      CD = 1'b1;
      tick();
      check("rst_perr", D_PERR, 0);
      check("rst_ovf", OVF, 0);
      check("rst_ferr", FERR, 0);
      check("rst_state", dbg_state, 0);

      // table-driven frames
      for (int i = 0; i < 7; i++) begin
         send_frame(vecs[i].data, vecs[i].par, vecs[i].gap_pos, vecs[i].gap_len);
         check($sformatf("vec%0d_vld", i), D_VLD, 1);
         check($sformatf("vec%0d_dout", i), DOUT, vecs[i].exp_dout);
         check($sformatf("vec%0d_perr", i), D_PERR, vecs[i].exp_perr);
         check($sformatf("vec%0d_ovf", i), OVF, 0);
         check($sformatf("vec%0d_ferr", i), FERR, 0);
         check($sformatf("vec%0d_busy", i), BUSY, 0);
         exp_q.push_back(vecs[i].exp_dout);
         pop_word();
         check($sformatf("vec%0d_vld_drop", i), D_VLD, 0);
      end

      // back-to-back with consumer always ready
      D_RDY = 1'b1;
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hFF);
      send_frame(8'h3C, 1'b0, 4, 3);
      send_frame(8'hFF, 1'b0, -1, 0);
      check("b2b_dout", DOUT, 8'hFF);
      tick();
      D_RDY = 1'b0;
      check("b2b_ovf", OVF, 0);
      check("b2b_drained", exp_q.size(), 0);
      check("b2b_vld", D_VLD, 0);

      // overflow
      send_frame(8'h11, 1'b0, -1, 0);
      send_frame(8'h22, 1'b0, -1, 0);
      check("ovf_dout", DOUT, 8'h11);
      check("ovf_vld", D_VLD, 1);
      check("ovf_flag", OVF, 1);
      exp_q.push_back(8'h11);
      pop_word();
      check("ovf_vld_drop", D_VLD, 0);
      check("ovf_still_set", OVF, 1);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      check("ovf_clear", OVF, 0);

      // SOF mid-frame restarts the frame
      send_bit(1'b1, 1'b1);
      for (int i = 1; i < 4; i++) send_bit(1'b1, 1'b0);
      check("frm_busy", BUSY, 1);
      check("frm_ferr_pre", FERR, 0);
      send_frame(8'h5A, 1'b0, -1, 0);
      check("frm_ferr", FERR, 1);
      check("frm_dout", DOUT, 8'h5A);
      check("frm_perr", D_PERR, 0);
      exp_q.push_back(8'h5A);
      pop_word();
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      check("frm_ferr_clr", FERR, 0);

      // stray bit in IDLE, then error colliding with clear
      send_bit(1'b1, 1'b0);
      check("stray_ferr", FERR, 1);
      check("stray_busy", BUSY, 0);
      check("stray_vld", D_VLD, 0);
      CLR_ERR = 1'b1;
      send_bit(1'b0, 1'b0);
      CLR_ERR = 1'b0;
      check("clr_collide", FERR, 1);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      check("clr_after", FERR, 0);

      // asynchronous reset mid-frame with a buffered word
      send_frame(8'h11, 1'b0, -1, 0);
      check("rmid_vld_pre", D_VLD, 1);
      send_bit(1'b1, 1'b1);
      for (int i = 1; i < 5; i++) send_bit(1'b1, 1'b0);
      check("rmid_busy_pre", BUSY, 1);
      #2;
      CD = 1'b0;
      #1;
      check("rmid_vld", D_VLD, 0);
      check("rmid_dout", DOUT, 0);
      check("rmid_busy", BUSY, 0);
      check("rmid_perr", D_PERR, 0);
      tick();
      CD = 1'b1;
      tick();
      send_frame(8'h77, 1'b0, -1, 0);
      check("post_rst_vld", D_VLD, 1);
      check("post_rst_dout", DOUT, 8'h77);
      check("post_rst_ferr", FERR, 0);
      exp_q.push_back(8'h77);
      pop_word();
      tick();
      check("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
